mips_run_ctrl: RTL and testbench
================================

Name: mips_run_ctrl

Overview:
Run-control unit placed between the board-level controls and the MIPS core. It replaces the fixed run/step FSM with a parametrised one that supports free-run, N-instruction stepping and a programmable breakpoint bank. It drives a per-cycle clock enable `cpu_en` into the core's PC and register/memory write paths. One instruction retires per enabled cycle.

Parameters:
PC_W, 6, width of instruction-memory index (pc) and breakpoint addresses
CNT_W, 8, width of step-count load, steps-remaining and retired-instruction counters
NUM_BP, 2, number of breakpoint slots (1..8)
BP_IDX_W, 1, width of breakpoint index; must be at least 1 and at least clog2(NUM_BP)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
change  in  1  run/halt toggle, level input, rising edge acts
step  in  1  step request, level input, rising edge acts
step_n  in  CNT_W  instructions per step request; 0 is treated as 1
pc  in  PC_W  address of the instruction the core executes when cpu_en=1
bp_we  in  1  breakpoint slot write strobe
bp_sel  in  BP_IDX_W  slot written
bp_addr_in  in  PC_W  breakpoint address written
bp_valid_in  in  1  slot enable written
cpu_en  out  1  core advances one instruction this cycle
halted  out  1  FSM in HALT
bp_hit  out  1  last halt was caused by a breakpoint
bp_idx  out  BP_IDX_W  slot that caused bp_hit
steps_left  out  CNT_W  remaining instructions of current step burst
retired  out  CNT_W  count of enabled cycles, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=0, async):
  - state=HALT, halted=1, cpu_en=0, bp_hit=0, bp_idx=0, steps_left=0, retired=0.
  - All breakpoint slots invalid; edge registers cleared to 0.
- Edge detection: change_q/step_q are registered copies. chg_edge = change & ~change_q; stp_edge = step & ~step_q. Both act at the same clock edge they are seen. A level held high produces exactly one edge.
- States: HALT=2'b00, RUN=2'b01, STEP=2'b10; 2'b11 is illegal and goes to HALT.
- HALT:
  - chg_edge -> RUN, bp_hit<=0, skip<=1.
  - Else stp_edge -> STEP, steps_left <= (step_n==0 ? 1 : step_n), bp_hit<=0.
- RUN:
  - chg_edge -> HALT.
  - Else if bp_match & ~skip -> HALT, bp_hit<=1, bp_idx <= lowest matching slot.
  - skip clears after the first RUN cycle. This lets execution resume from a breakpointed pc.
  - stp_edge is ignored.
- STEP:
  - chg_edge -> HALT, steps_left<=0 (abort).
  - Else each cycle steps_left decrements; when steps_left==1 -> HALT, steps_left<=0.
  - Breakpoints and stp_edge are ignored.
- Simultaneous chg_edge and stp_edge: change wins, step is dropped.
- cpu_en (combinational): (state==RUN & ~(bp_match & ~skip) & ~chg_edge) | (state==STEP & ~chg_edge).
  - A halting condition therefore suppresses execution in the same cycle.
  - A breakpointed instruction is never executed on the halting cycle.
- retired increments on every cycle with cpu_en=1 and wraps 2^CNT_W-1 -> 0.
- halted = (state==HALT), combinational.
- bp_match = OR over valid slots of (pc == slot addr).
- Breakpoint slot write:
  - On bp_we, slot bp_sel is written at the clock edge and takes effect next cycle.
  - bp_sel >= NUM_BP is ignored.
  - Writes are allowed in any state.
- Latency:
  - chg_edge in HALT -> cpu_en=1 the following cycle.
  - A step burst of N yields exactly N consecutive cpu_en cycles, starting the cycle after stp_edge.
- Reset mid-burst or mid-run: immediate HALT. The breakpoint configuration is lost.

Decomposition:
- Shared include mips_run_ctrl.vh: state encodings HALT/RUN/STEP and the STATE_W=2 constant.
- One sub-module, mips_bp_match:
  - Holds the NUM_BP slot registers and write port.
  - Outputs bp_match and the lowest-index match.
  - Is purely compare logic plus slot storage.

Test Plan:
- Reset: rst=0 while step_n=5, change toggling -> cpu_en=0, halted=1, retired=0, steps_left=0 throughout.
- Free run/halt: change 0->1 -> cpu_en=1 from the next cycle; after 10 cycles change 1->0->1 -> HALT on that edge, retired=10.
- N-step: in HALT, step_n=3, step 0->1 -> exactly 3 cpu_en cycles, steps_left 3,2,1 then HALT, retired +3. Repeat with step_n=0 -> exactly 1 cycle.
- Breakpoint:
  - Slot 1 = addr 7, valid; run with pc incrementing from 0 -> cpu_en=0 when pc=7, halted=1, bp_hit=1, bp_idx=1, retired=7.
  - change edge -> pc 7 executes, run continues.
- Simultaneous events:
  - change and step rising in the same cycle from HALT -> RUN, steps_left=0.
  - change edge during a step_n=8 burst at steps_left=5 -> HALT, steps_left=0.
- Wrap and reset mid-operation: CNT_W=8, run 260 cycles -> retired=4. Assert rst=0 mid-STEP -> immediate HALT, and bp slots are invalid after release.

Source files
------------

// File: rtl/mips_run_ctrl_pkg.sv
// State encodings shared by the MIPS run-control unit.
// The 2-bit values match the legacy run/step FSM so existing debug tooling still decodes them.
package mips_run_ctrl_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] HALT = 2'b00;
  localparam logic [STATE_W-1:0] RUN  = 2'b01;
  localparam logic [STATE_W-1:0] STEP = 2'b10;

endpackage

// File: rtl/mips_bp_match.sv
// Breakpoint bank: NUM_BP address/valid slots compared against the current pc.
// Reports whether any valid slot matches and the lowest-index matching slot.
module mips_bp_match #(
  parameter int PC_W     = 6,
  parameter int NUM_BP   = 2,
  parameter int BP_IDX_W = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bp_we,
  input  logic [BP_IDX_W-1:0] bp_sel,
  input  logic [PC_W-1:0]     bp_addr_in,
  input  logic                bp_valid_in,
  input  logic [PC_W-1:0]     pc,
  output logic                bp_match,
  output logic [BP_IDX_W-1:0] bp_first
);

  logic [PC_W-1:0]   slot_addr [NUM_BP];
  logic [NUM_BP-1:0] slot_valid;

  // A select value with no slot behind it matches no loop index, so the write is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid <= '0;
      for (int i = 0; i < NUM_BP; i++) begin
        slot_addr[i] <= '0;
      end
    end else if (bp_we) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (32'(bp_sel) == i) begin
          slot_addr[i]  <= bp_addr_in;
          slot_valid[i] <= bp_valid_in;
        end
      end
    end
  end

  // Scanning from the top slot down leaves the lowest matching index as the final value.
  always_comb begin
    bp_match = 1'b0;
    bp_first = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (slot_valid[i] && (slot_addr[i] == pc)) begin
        bp_match = 1'b1;
        bp_first = BP_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run-control for the MIPS core: free-run, N-instruction stepping and breakpoints.
// cpu_en gates the core's PC and write paths, so each enabled cycle retires one instruction.
module mips_run_ctrl #(
  parameter int PC_W     = 6,
  parameter int CNT_W    = 8,
  parameter int NUM_BP   = 2,
  parameter int BP_IDX_W = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                change,
  input  logic                step,
  input  logic [CNT_W-1:0]    step_n,
  input  logic [PC_W-1:0]     pc,
  input  logic                bp_we,
  input  logic [BP_IDX_W-1:0] bp_sel,
  input  logic [PC_W-1:0]     bp_addr_in,
  input  logic                bp_valid_in,
  output logic                cpu_en,
  output logic                halted,
  output logic                bp_hit,
  output logic [BP_IDX_W-1:0] bp_idx,
  output logic [CNT_W-1:0]    steps_left,
  output logic [CNT_W-1:0]    retired
);

  import mips_run_ctrl_pkg::*;

  logic [STATE_W-1:0]  state;
  logic                change_q;
  logic                step_q;
  logic                skip;
  logic                chg_edge;
  logic                stp_edge;
  logic                bp_match;
  logic                bp_stop;
  logic [BP_IDX_W-1:0] bp_first;

  mips_bp_match #(
    .PC_W     (PC_W),
    .NUM_BP   (NUM_BP),
    .BP_IDX_W (BP_IDX_W)
  ) u_bp_match (
    .clk         (clk),
    .rst         (rst),
    .bp_we       (bp_we),
    .bp_sel      (bp_sel),
    .bp_addr_in  (bp_addr_in),
    .bp_valid_in (bp_valid_in),
    .pc          (pc),
    .bp_match    (bp_match),
    .bp_first    (bp_first)
  );

  assign chg_edge = change & ~change_q;
  assign stp_edge = step & ~step_q;
  // skip masks the breakpoint for the first RUN cycle so a halted-on pc can be resumed.
  assign bp_stop  = bp_match & ~skip;
  assign halted   = (state == HALT);
  assign cpu_en   = ((state == RUN) & ~bp_stop & ~chg_edge) | ((state == STEP) & ~chg_edge);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HALT;
      change_q   <= 1'b0;
      step_q     <= 1'b0;
      skip       <= 1'b0;
      bp_hit     <= 1'b0;
      bp_idx     <= '0;
      steps_left <= '0;
      retired    <= '0;
    end else begin
      change_q <= change;
      step_q   <= step;
      if (cpu_en) begin
        retired <= retired + 1'b1;
      end
      // change has priority over step everywhere, so a simultaneous step edge is dropped.
      case (state)
        HALT: begin
          if (chg_edge) begin
            state  <= RUN;
            bp_hit <= 1'b0;
            skip   <= 1'b1;
          end else if (stp_edge) begin
            state      <= STEP;
            steps_left <= (step_n == '0) ? CNT_W'(1) : step_n;
            bp_hit     <= 1'b0;
          end
        end
        RUN: begin
          skip <= 1'b0;
          if (chg_edge) begin
            state <= HALT;
          end else if (bp_stop) begin
            state  <= HALT;
            bp_hit <= 1'b1;
            bp_idx <= bp_first;
          end
        end
        STEP: begin
          if (chg_edge || (steps_left <= CNT_W'(1))) begin
            state      <= HALT;
            steps_left <= '0;
          end else begin
            steps_left <= steps_left - 1'b1;
          end
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: directed scenarios plus a randomized run,
// all compared against a behavioural model of the run/step/breakpoint rules.
module tb_mips_run_ctrl;

  localparam int PC_W     = 6;
  localparam int CNT_W    = 8;
  localparam int NUM_BP   = 3;
  localparam int BP_IDX_W = 2;

  logic                clk;
  logic                rst;
  logic                change;
  logic                step;
  logic [CNT_W-1:0]    step_n;
  logic [PC_W-1:0]     pc;
  logic                bp_we;
  logic [BP_IDX_W-1:0] bp_sel;
  logic [PC_W-1:0]     bp_addr_in;
  logic                bp_valid_in;
  logic                cpu_en;
  logic                halted;
  logic                bp_hit;
  logic [BP_IDX_W-1:0] bp_idx;
  logic [CNT_W-1:0]    steps_left;
  logic [CNT_W-1:0]    retired;

  int n_compared;
  int n_mismatched;

  // Behavioural model: running flag, remaining burst length, resume flag, breakpoint table.
  bit m_running;
  int m_burst;
  bit m_resume;
  bit m_bp_hit;
  int m_bp_idx;
  int m_retired;
  int m_pc;
  bit m_prev_change;
  bit m_prev_step;
  int m_bp_addr [NUM_BP];
  bit m_bp_valid [NUM_BP];

  mips_run_ctrl #(
    .PC_W     (PC_W),
    .CNT_W    (CNT_W),
    .NUM_BP   (NUM_BP),
    .BP_IDX_W (BP_IDX_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .change      (change),
    .step        (step),
    .step_n      (step_n),
    .pc          (pc),
    .bp_we       (bp_we),
    .bp_sel      (bp_sel),
    .bp_addr_in  (bp_addr_in),
    .bp_valid_in (bp_valid_in),
    .cpu_en      (cpu_en),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .bp_idx      (bp_idx),
    .steps_left  (steps_left),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_running     = 1'b0;
    m_burst       = 0;
    m_resume      = 1'b0;
    m_bp_hit      = 1'b0;
    m_bp_idx      = 0;
    m_retired     = 0;
    m_prev_change = 1'b0;
    m_prev_step   = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      m_bp_addr[i]  = 0;
      m_bp_valid[i] = 1'b0;
    end
  endfunction

  function automatic int model_first();
    for (int i = 0; i < NUM_BP; i++) begin
      if (m_bp_valid[i] && (m_bp_addr[i] == int'(pc))) return i;
    end
    return -1;
  endfunction

  function automatic logic model_en();
    bit ce;
    ce = change && !m_prev_change;
    if (m_running) return !ce && !((model_first() >= 0) && !m_resume);
    if (m_burst > 0) return !ce;
    return 1'b0;
  endfunction

  function automatic logic model_halted();
    return !m_running && (m_burst == 0);
  endfunction

  // One clock: the model consumes the inputs present at the rising edge; the core pc follows.
  task automatic tick();
    bit en;
    bit ce;
    bit se;
    int hit;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      en  = model_en();
      hit = model_first();
      ce  = change && !m_prev_change;
      se  = step && !m_prev_step;
      if (en) begin
        m_retired = (m_retired + 1) % (1 << CNT_W);
        m_pc      = (m_pc + 1) % (1 << PC_W);
      end
      if (m_running) begin
        if (ce) begin
          m_running = 1'b0;
        end else if ((hit >= 0) && !m_resume) begin
          m_running = 1'b0;
          m_bp_hit  = 1'b1;
          m_bp_idx  = hit;
        end
        m_resume = 1'b0;
      end else if (m_burst > 0) begin
        m_burst = ce ? 0 : m_burst - 1;
      end else if (ce) begin
        m_running = 1'b1;
        m_bp_hit  = 1'b0;
        m_resume  = 1'b1;
      end else if (se) begin
        m_burst  = (step_n == '0) ? 1 : int'(step_n);
        m_bp_hit = 1'b0;
      end
      if (bp_we && (int'(bp_sel) < NUM_BP)) begin
        m_bp_addr[int'(bp_sel)]  = int'(bp_addr_in);
        m_bp_valid[int'(bp_sel)] = bp_valid_in;
      end
      m_prev_change = change;
      m_prev_step   = step;
    end
    @(negedge clk);
    pc = PC_W'(m_pc);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    model_reset();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic write_bp(input int sel, input int addr, input bit valid);
    bp_we       = 1'b1;
    bp_sel      = BP_IDX_W'(sel);
    bp_addr_in  = PC_W'(addr);
    bp_valid_in = valid;
    tick();
    bp_we = 1'b0;
  endtask

  // Reset held while step_n and change/step wiggle: everything must stay quiet.
  task automatic test_reset();
    rst = 1'b0;
    step_n = CNT_W'(5);
    for (int i = 0; i < 4; i++) begin
      change = i[0];
      step   = ~i[0];
      #1;
      n_compared++; if (cpu_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_cpu_en: got %b expected 0", cpu_en); end
      n_compared++; if (halted !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_halted: got %b expected 1", halted); end
      n_compared++; if (retired !== '0) begin n_mismatched++; $display("[TB] FAIL reset_retired: got %0d expected 0", retired); end
      n_compared++; if (steps_left !== '0) begin n_mismatched++; $display("[TB] FAIL reset_steps_left: got %0d expected 0", steps_left); end
      n_compared++; if ((bp_hit !== 1'b0) || (bp_idx !== '0)) begin n_mismatched++; $display("[TB] FAIL reset_bp: got hit=%b idx=%0d expected hit=0 idx=0", bp_hit, bp_idx); end
      tick();
    end
    change = 1'b0;
    step   = 1'b0;
    rst    = 1'b1;
    tick();
  endtask

  task automatic test_free_run();
    m_pc = 0;
    pc   = '0;
    change = 1'b1;
    #1;
    n_compared++; if (cpu_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL run_edge_cpu_en: got %b expected 0", cpu_en); end
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 9) change = 1'b0;
      #1;
      n_compared++; if (cpu_en !== 1'b1) begin n_mismatched++; $display("[TB] FAIL run_cpu_en[%0d]: got %b expected 1", i, cpu_en); end
      tick();
    end
    change = 1'b1;
    #1;
    n_compared++; if (cpu_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL run_halt_cpu_en: got %b expected 0", cpu_en); end
    tick();
    n_compared++; if (halted !== 1'b1) begin n_mismatched++; $display("[TB] FAIL run_halted: got %b expected 1", halted); end
    n_compared++; if (retired !== CNT_W'(10)) begin n_mismatched++; $display("[TB] FAIL run_retired: got %0d expected 10", retired); end
  endtask

  task automatic test_step();
    change = 1'b0;
    tick();
    step_n = CNT_W'(3);
    step   = 1'b1;
    #1;
    n_compared++; if (cpu_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL step_edge_cpu_en: got %b expected 0", cpu_en); end
    tick();
    for (int k = 3; k >= 1; k--) begin
      #1;
      n_compared++; if ((cpu_en !== 1'b1) || (steps_left !== CNT_W'(k))) begin n_mismatched++; $display("[TB] FAIL step_burst: got en=%b left=%0d expected en=1 left=%0d", cpu_en, steps_left, k); end
      tick();
    end
    #1;
    n_compared++; if ((halted !== 1'b1) || (cpu_en !== 1'b0) || (steps_left !== '0)) begin n_mismatched++; $display("[TB] FAIL step_end: got halted=%b en=%b left=%0d expected 1/0/0", halted, cpu_en, steps_left); end
    n_compared++; if (retired !== CNT_W'(13)) begin n_mismatched++; $display("[TB] FAIL step_retired: got %0d expected 13", retired); end
    step = 1'b0;
    tick();
    step_n = '0;
    step   = 1'b1;
    tick();
    #1;
    n_compared++; if ((cpu_en !== 1'b1) || (steps_left !== CNT_W'(1))) begin n_mismatched++; $display("[TB] FAIL step_zero: got en=%b left=%0d expected en=1 left=1", cpu_en, steps_left); end
    tick();
    n_compared++; if ((halted !== 1'b1) || (retired !== CNT_W'(14))) begin n_mismatched++; $display("[TB] FAIL step_zero_end: got halted=%b retired=%0d expected 1/14", halted, retired); end
    step = 1'b0;
    tick();
  endtask

  task automatic test_breakpoint();
    int n;
    apply_reset();
    write_bp(1, 7, 1'b1);
    write_bp(2, 7, 1'b1);
    write_bp(3, 2, 1'b1);
    m_pc = 0;
    pc   = '0;
    change = 1'b1;
    tick();
    n = 0;
    while ((halted !== 1'b1) && (n < 40)) begin
      #1;
      if (pc == PC_W'(7)) begin
        n_compared++; if (cpu_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_pc7_cpu_en: got %b expected 0", cpu_en); end
      end
      n_compared++; if (cpu_en !== model_en()) begin n_mismatched++; $display("[TB] FAIL bp_run_cpu_en: got %b expected %b at pc %0d", cpu_en, model_en(), pc); end
      tick();
      n++;
    end
    n_compared++; if (halted !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_timeout: got halted=%b expected 1 within 40 cycles", halted); end
    n_compared++; if ((bp_hit !== 1'b1) || (bp_idx !== BP_IDX_W'(1))) begin n_mismatched++; $display("[TB] FAIL bp_hit_idx: got hit=%b idx=%0d expected hit=1 idx=1", bp_hit, bp_idx); end
    n_compared++; if (retired !== CNT_W'(7)) begin n_mismatched++; $display("[TB] FAIL bp_retired: got %0d expected 7", retired); end
    change = 1'b0;
    tick();
    change = 1'b1;
    tick();
    #1;
    n_compared++; if ((cpu_en !== 1'b1) || (pc !== PC_W'(7))) begin n_mismatched++; $display("[TB] FAIL bp_resume: got en=%b at pc %0d expected en=1 at pc 7", cpu_en, pc); end
    tick();
    n_compared++; if ((bp_hit !== 1'b0) || (retired !== CNT_W'(8)) || (halted !== 1'b0)) begin n_mismatched++; $display("[TB] FAIL bp_after_resume: got hit=%b retired=%0d halted=%b expected 0/8/0", bp_hit, retired, halted); end
    change = 1'b0;
    tick();
    change = 1'b1;
    tick();
    n_compared++; if ((halted !== 1'b1) || (retired !== CNT_W'(m_retired))) begin n_mismatched++; $display("[TB] FAIL bp_final: got halted=%b retired=%0d expected 1/%0d", halted, retired, m_retired); end
  endtask

  task automatic test_simultaneous();
    int n;
    change = 1'b0;
    step   = 1'b0;
    tick();
    step_n = CNT_W'(4);
    change = 1'b1;
    step   = 1'b1;
    tick();
    #1;
    n_compared++; if ((halted !== 1'b0) || (steps_left !== '0) || (cpu_en !== 1'b1)) begin n_mismatched++; $display("[TB] FAIL simul_change_wins: got halted=%b left=%0d en=%b expected 0/0/1", halted, steps_left, cpu_en); end
    change = 1'b0;
    tick();
    change = 1'b1;
    tick();
    change = 1'b0;
    step   = 1'b0;
    tick();
    step_n = CNT_W'(8);
    step   = 1'b1;
    tick();
    n = 0;
    while ((steps_left !== CNT_W'(5)) && (n < 10)) begin
      tick();
      n++;
    end
    n_compared++; if (steps_left !== CNT_W'(5)) begin n_mismatched++; $display("[TB] FAIL abort_reach5: got %0d expected 5 within 10 cycles", steps_left); end
    change = 1'b1;
    #1;
    n_compared++; if (cpu_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_cpu_en: got %b expected 0", cpu_en); end
    tick();
    n_compared++; if ((halted !== 1'b1) || (steps_left !== '0)) begin n_mismatched++; $display("[TB] FAIL abort_state: got halted=%b left=%0d expected 1/0", halted, steps_left); end
    n_compared++; if (retired !== CNT_W'(m_retired)) begin n_mismatched++; $display("[TB] FAIL abort_retired: got %0d expected %0d", retired, m_retired); end
    change = 1'b0;
    step   = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    apply_reset();
    change = 1'b1;
    tick();
    for (int i = 0; i < 260; i++) begin
      if (i == 259) change = 1'b0;
      tick();
    end
    change = 1'b1;
    tick();
    n_compared++; if ((halted !== 1'b1) || (retired !== CNT_W'(4))) begin n_mismatched++; $display("[TB] FAIL wrap_retired: got halted=%b retired=%0d expected 1/4", halted, retired); end
    change = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_step();
    write_bp(0, (m_pc + 5) % (1 << PC_W), 1'b1);
    step_n = CNT_W'(8);
    step   = 1'b1;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    n_compared++; if ((halted !== 1'b1) || (cpu_en !== 1'b0) || (steps_left !== '0) || (retired !== '0)) begin n_mismatched++; $display("[TB] FAIL midreset: got halted=%b en=%b left=%0d retired=%0d expected 1/0/0/0", halted, cpu_en, steps_left, retired); end
    model_reset();
    tick();
    rst  = 1'b1;
    step = 1'b0;
    tick();
    change = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      n_compared++; if ((halted !== 1'b0) || (cpu_en !== 1'b1)) begin n_mismatched++; $display("[TB] FAIL midreset_bp_cleared[%0d]: got halted=%b en=%b expected 0/1", i, halted, cpu_en); end
      tick();
    end
    change = 1'b0;
    tick();
    change = 1'b1;
    tick();
    change = 1'b0;
    tick();
  endtask

  // Random mix of toggles, step sizes, breakpoint writes, pc values and rare resets.
  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0) change = ~change;
      if ($urandom_range(0, 4) == 0) step = ~step;
      step_n      = CNT_W'($urandom_range(0, 6));
      pc          = PC_W'($urandom_range(0, 7));
      bp_we       = ($urandom_range(0, 5) == 0);
      bp_sel      = BP_IDX_W'($urandom_range(0, 3));
      bp_addr_in  = PC_W'($urandom_range(0, 7));
      bp_valid_in = 1'($urandom_range(0, 1));
      rst         = ($urandom_range(0, 149) != 0);
      #1;
      if (!rst) model_reset();
      n_compared++; if (cpu_en !== model_en()) begin n_mismatched++; $display("[TB] FAIL rnd_cpu_en[%0d]: got %b expected %b", c, cpu_en, model_en()); end
      n_compared++; if (halted !== model_halted()) begin n_mismatched++; $display("[TB] FAIL rnd_halted[%0d]: got %b expected %b", c, halted, model_halted()); end
      n_compared++; if (steps_left !== CNT_W'(m_burst)) begin n_mismatched++; $display("[TB] FAIL rnd_steps_left[%0d]: got %0d expected %0d", c, steps_left, m_burst); end
      n_compared++; if (retired !== CNT_W'(m_retired)) begin n_mismatched++; $display("[TB] FAIL rnd_retired[%0d]: got %0d expected %0d", c, retired, m_retired); end
      n_compared++; if ((bp_hit !== m_bp_hit) || (bp_idx !== BP_IDX_W'(m_bp_idx))) begin n_mismatched++; $display("[TB] FAIL rnd_bp[%0d]: got hit=%b idx=%0d expected hit=%b idx=%0d", c, bp_hit, bp_idx, m_bp_hit, m_bp_idx); end
      tick();
    end
    bp_we = 1'b0;
    rst   = 1'b1;
  endtask

  initial begin
    clk          = 1'b0;
    rst          = 1'b1;
    change       = 1'b0;
    step         = 1'b0;
    step_n       = '0;
    pc           = '0;
    bp_we        = 1'b0;
    bp_sel       = '0;
    bp_addr_in   = '0;
    bp_valid_in  = 1'b0;
    n_compared   = 0;
    n_mismatched = 0;
    m_pc         = 0;
    model_reset();
    #2;
    @(negedge clk);
    test_reset();
    test_free_run();
    test_step();
    test_breakpoint();
    test_simultaneous();
    test_wrap();
    test_reset_mid_step();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
